// File: rtl/fifo_rr_dispatch.sv
// fifo_rr_dispatch
// Moves one word per cycle from four input FIFOs to four output FIFOs.
// A round-robin arbiter picks a non-empty input and pops it. One cycle
// later the popped word is pushed to the output FIFO named by its 2-bit
// destination field. Any almost_full on the output side holds back new pops,
// but a word that is already in flight is still delivered.

module fifo_rr_dispatch #(
  parameter int WORD_SIZE = 6,
  parameter int N_PORTS   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_PORTS-1:0]           in_empty,
  input  logic [N_PORTS*WORD_SIZE-1:0] in_data,
  output logic [N_PORTS-1:0]           in_pop,
  input  logic [N_PORTS-1:0]           out_almost_full,
  output logic [N_PORTS-1:0]           out_push,
  output logic [WORD_SIZE-1:0]         out_data,
  output logic [1:0]                   state,
  output logic [7:0]                   words_moved
);

  // The destination field is two bits wide, so exactly four ports can be indexed.
  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2
  } state_t;

  // Pop stage
  idx_t   grant_ptr;   // last input granted; search starts one past it
  idx_t   arb_cand;
  idx_t   arb_idx;
  logic   arb_hit;
  logic   stall;
  logic   pop_en;

  // Push stage
  logic                 valid_q;  // a word popped last cycle is on in_data[sel_q]
  idx_t                 sel_q;
  logic [WORD_SIZE-1:0] sel_word;
  idx_t                 dest;
  logic                 push_en;

  // Status
  state_t     state_q;
  state_t     state_d;
  logic [7:0] words_q;

  // Global back-pressure: any output near full holds back all pops.
  assign stall = |out_almost_full;

  // Round-robin search from grant_ptr+1 (mod 4); the first non-empty input wins.
  always_comb begin
    // NOTE: every variable written here gets a value before the loop, so no path
    // leaves one unassigned and no latch is inferred.
    arb_hit  = 1'b0;
    arb_idx  = grant_ptr;
    arb_cand = grant_ptr;
    for (int k = 1; k <= N_PORTS; k++) begin
      arb_cand = grant_ptr + idx_t'(k);
      if (!arb_hit && !in_empty[arb_cand]) begin
        arb_hit = 1'b1;
        arb_idx = arb_cand;
      end
    end
  end

  // A pop happens only when a candidate exists, nothing is stalled and
  // reset is not being applied.
  assign pop_en = arb_hit && !stall && !reset;

  // One-hot pop to the granted input.
  always_comb begin
    in_pop = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      in_pop[i] = pop_en && (arb_idx == idx_t'(i));
    end
  end

  // The upstream FIFO presents the popped word in the cycle after the pop.
  assign sel_word = in_data[int'(sel_q)*WORD_SIZE +: WORD_SIZE];
  assign dest     = sel_word[WORD_SIZE-1 -: IDX_W];

  // A word in flight is always pushed, even under stall. Reset discards it.
  assign push_en = valid_q && !reset;

  // Push the word in flight to its destination; drive zero data otherwise.
  always_comb begin
    out_push = '0;
    out_data = push_en ? sel_word : '0;
    for (int j = 0; j < N_PORTS; j++) begin
      out_push[j] = push_en && (dest == idx_t'(j));
    end
  end

  // Arbitration pointer and in-flight tracking.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every flop here
    // samples values from before this edge and ordering between blocks is irrelevant.
    if (reset) begin
      grant_ptr <= idx_t'(N_PORTS - 1);  // input 0 gets first priority
      valid_q   <= 1'b0;
      sel_q     <= '0;
    end else begin
      valid_q <= pop_en;
      if (pop_en) begin
        grant_ptr <= arb_idx;
        sel_q     <= arb_idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. Stall has priority, then pending input, then idle.
  always_comb begin
    state_d = state_q;
    if (stall) begin
      state_d = ST_STALL;
    end else if (!(&in_empty)) begin
      state_d = ST_ACTIVE;
    end else begin
      state_d = ST_IDLE;
    end
  end

  assign state = state_q;

  // Count every pushed word. The counter wraps naturally from 255 to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      words_q <= '0;
    end else if (|out_push) begin
      words_q <= words_q + 8'd1;
    end
  end

  assign words_moved = words_q;

endmodule
